mcp01_controller: RTL and testbench

- Multicycle control FSM for the MCP01 stack-based datapath.
- Takes the 3-bit opcode from the IR and generates every datapath strobe: IorD, MemRead, IR_Write, PC_Write, PCsel, d_in_sel, push, pop, MemWrite, ldop1, ldop2, ALU_Src_A/B, ALU_Control, tos, JZ.
- Tracks stack depth itself so it can trap underflow and overflow before the datapath corrupts the stack.
- Sits beside the datapath at top level, sharing clk/rst.

---
 rtl/mcp01_if.sv | 47 ++++
 rtl/mcp01_controller.sv | 174 +++++++++++++++++
 tb/tb_mcp01_controller.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcp01_if.sv
// mcp01_if: controller <-> datapath bundle for the MCP01 machine.
// Purpose: carries the run request and IR opcode into the controller and every
//          datapath strobe plus status/debug back out.
// Ports (modports):
//   master - controller side: takes run/opcode, drives strobes and status.
//   slave  - datapath/observer side: drives run/opcode, takes strobes and status.
interface mcp01_if #(
  parameter int DW = 6
);
  logic          run;
  logic [2:0]    opcode;
  logic          IorD;
  logic          MemRead;
  logic          IR_Write;
  logic          PC_Write;
  logic          PCsel;
  logic          d_in_sel;
  logic          push;
  logic          pop;
  logic          MemWrite;
  logic          ldop1;
  logic          ldop2;
  logic          ALU_Src_A;
  logic          ALU_Src_B;
  logic          tos;
  logic          JZ;
  logic [1:0]    ALU_Control;
  logic [DW-1:0] depth;
  logic          busy;
  logic          instr_done;
  logic          err;
  logic [3:0]    state;

  modport master (
    input  run, opcode,
    output IorD, MemRead, IR_Write, PC_Write, PCsel, d_in_sel, push, pop,
           MemWrite, ldop1, ldop2, ALU_Src_A, ALU_Src_B, tos, JZ, ALU_Control,
           depth, busy, instr_done, err, state
  );

  modport slave (
    output run, opcode,
    input  IorD, MemRead, IR_Write, PC_Write, PCsel, d_in_sel, push, pop,
           MemWrite, ldop1, ldop2, ALU_Src_A, ALU_Src_B, tos, JZ, ALU_Control,
           depth, busy, instr_done, err, state
  );
endinterface

// File: rtl/mcp01_controller.sv
// mcp01_controller: multicycle control FSM for the MCP01 stack datapath.
// Purpose: sequences fetch/decode/execute for the 8-instruction stack ISA,
//          tracks stack occupancy and traps underflow/overflow in DECODE
//          before any stack strobe is issued.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous reset, active low
//   bus - mcp01_if.master: run/opcode in; strobes, depth, busy,
//         instr_done, err and state out
module mcp01_controller #(
  parameter int STACK_DEPTH = 32,
  parameter int DW          = 6
) (
  input  logic      clk,
  input  logic      rst,
  mcp01_if.master   bus
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, POP_A, POP_B, LD_B, LD_A, EXEC,
    WB, MEM_RD, PUSH_WB, MEM_WR, JMP, TOS, JZ_CHK, ERR
  } state_t;

  state_t        state_reg, state_next;
  logic [DW-1:0] depth_reg, depth_next;
  logic          fault;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      depth_reg <= '0;
    end else begin
      state_reg <= state_next;
      depth_reg <= depth_next;
    end
  end

  // Stack check for the instruction sitting in the IR; only consulted in DECODE.
  always_comb begin
    fault = 1'b0;
    case (bus.opcode)
      3'b000, 3'b001, 3'b010: fault = (depth_reg < DW'(2));
      3'b011, 3'b101, 3'b111: fault = (depth_reg == '0);
      3'b100:                 fault = (depth_reg == DW'(STACK_DEPTH));
      default:                fault = 1'b0;
    endcase
  end

  always_comb begin
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.IR_Write    = 1'b0;
    bus.PC_Write    = 1'b0;
    bus.PCsel       = 1'b0;
    bus.d_in_sel    = 1'b0;
    bus.push        = 1'b0;
    bus.pop         = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.ldop1       = 1'b0;
    bus.ldop2       = 1'b0;
    bus.ALU_Src_A   = 1'b0;
    bus.ALU_Src_B   = 1'b0;
    bus.tos         = 1'b0;
    bus.JZ          = 1'b0;
    bus.ALU_Control = 2'b00;
    bus.instr_done  = 1'b0;
    state_next      = state_reg;
    depth_next      = depth_reg;

    case (state_reg)
      IDLE: if (bus.run) state_next = FETCH;
      FETCH: begin
        // ALU sources/op left at 0 so ALUout captures PC+1.
        bus.MemRead  = 1'b1;
        bus.IR_Write = 1'b1;
        state_next   = DECODE;
      end
      DECODE: begin
        if (fault) begin
          state_next = ERR;
        end else begin
          bus.PC_Write = 1'b1;
          case (bus.opcode)
            3'b100:  state_next = MEM_RD;
            3'b110:  state_next = JMP;
            3'b111:  state_next = TOS;
            default: state_next = POP_A;
          endcase
        end
      end
      POP_A: begin
        bus.pop    = 1'b1;
        depth_next = depth_reg - DW'(1);
        case (bus.opcode)
          3'b011:  state_next = LD_A;
          3'b101:  state_next = MEM_WR;
          default: state_next = POP_B;
        endcase
      end
      POP_B: begin
        // Old top is on d_out now; latch it as op1 while popping the next entry.
        bus.pop    = 1'b1;
        bus.ldop1  = 1'b1;
        depth_next = depth_reg - DW'(1);
        state_next = LD_B;
      end
      LD_B: begin
        bus.ldop2  = 1'b1;
        state_next = EXEC;
      end
      LD_A: begin
        bus.ldop1  = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        bus.ALU_Src_A   = 1'b1;
        bus.ALU_Src_B   = 1'b1;
        bus.ALU_Control = bus.opcode[1:0];
        state_next      = WB;
      end
      WB: begin
        bus.d_in_sel   = 1'b1;
        bus.push       = 1'b1;
        bus.instr_done = 1'b1;
        depth_next     = depth_reg + DW'(1);
        state_next     = FETCH;
      end
      MEM_RD: begin
        bus.IorD    = 1'b1;
        bus.MemRead = 1'b1;
        state_next  = PUSH_WB;
      end
      PUSH_WB: begin
        bus.IorD       = 1'b1;
        bus.MemRead    = 1'b1;
        bus.push       = 1'b1;
        bus.instr_done = 1'b1;
        depth_next     = depth_reg + DW'(1);
        state_next     = FETCH;
      end
      MEM_WR: begin
        bus.IorD       = 1'b1;
        bus.MemWrite   = 1'b1;
        bus.instr_done = 1'b1;
        state_next     = FETCH;
      end
      JMP: begin
        bus.PCsel      = 1'b1;
        bus.PC_Write   = 1'b1;
        bus.instr_done = 1'b1;
        state_next     = FETCH;
      end
      TOS: begin
        bus.tos    = 1'b1;
        state_next = JZ_CHK;
      end
      JZ_CHK: begin
        // Datapath loads PC only when d_out is zero.
        bus.PCsel      = 1'b1;
        bus.JZ         = 1'b1;
        bus.instr_done = 1'b1;
        state_next     = FETCH;
      end
      ERR:     state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

  assign bus.depth = depth_reg;
  assign bus.busy  = (state_reg != IDLE) && (state_reg != ERR);
  assign bus.err   = (state_reg == ERR);
  assign bus.state = state_reg;

endmodule

// File: tb/tb_mcp01_controller.sv
// tb_mcp01_controller: self-checking bench for mcp01_controller.
// A small behavioural datapath reacts to the controller strobes; an ISA-level
// model executes the same program one instruction at a time and predicts
// stack contents, PC, cycle counts and faults.
module tb_mcp01_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mcp01_if #(.DW(6)) bus ();

  mcp01_controller #(.STACK_DEPTH(32), .DW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- behavioural datapath ----------------
  logic [7:0] img [32];
  logic [7:0] mem [32];
  logic [7:0] stk [64];
  logic [7:0] ir, mdr, alu_out, op1, op2, d_out;
  logic [7:0] alu_a, alu_b, alu_y;
  logic [4:0] pc;
  int         sp;

  assign bus.opcode = ir[7:5];

  always_comb begin
    alu_a = bus.ALU_Src_A ? op1 : {3'b000, pc};
    alu_b = bus.ALU_Src_B ? op2 : 8'd1;
    case (bus.ALU_Control)
      2'b00:   alu_y = alu_a + alu_b;
      2'b01:   alu_y = alu_a - alu_b;
      2'b10:   alu_y = alu_a & alu_b;
      default: alu_y = ~alu_a;
    endcase
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= img[i];
      pc <= '0; ir <= '0; mdr <= '0; alu_out <= '0;
      op1 <= '0; op2 <= '0; d_out <= '0; sp <= 0;
    end else begin
      alu_out <= alu_y;
      if (bus.MemRead && !bus.IorD && bus.IR_Write) ir <= mem[pc];
      if (bus.MemRead && bus.IorD) mdr <= mem[ir[4:0]];
      if (bus.MemWrite) mem[ir[4:0]] <= d_out;
      if (bus.PC_Write) pc <= bus.PCsel ? ir[4:0] : alu_out[4:0];
      if (bus.JZ && d_out == 8'd0) pc <= ir[4:0];
      if (bus.ldop1) op1 <= d_out;
      if (bus.ldop2) op2 <= d_out;
      if (bus.pop && sp > 0) begin
        d_out <= stk[sp-1];
        sp    <= sp - 1;
      end
      if (bus.tos && sp > 0) d_out <= stk[sp-1];
      if (bus.push && sp < 64) begin
        stk[sp] <= bus.d_in_sel ? alu_out : mdr;
        sp      <= sp + 1;
      end
    end
  end

  // ---------------- ISA-level reference model ----------------
  logic [7:0] m_mem [32];
  logic [4:0] m_pc;
  logic [7:0] m_stk [$];

  function automatic logic [7:0] enc(input int op, input int addr);
    logic [7:0] v;
    v = {3'(op), 5'(addr)};
    return v;
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
  endtask

  // Executes the instruction at m_pc; reports expected cycles and strobe counts.
  task automatic model_step(output int cyc, output int n_push, output int n_pop,
                            output bit fault, output logic [2:0] op);
    logic [7:0] word, x, y;
    int         a, d;
    word = m_mem[m_pc];
    op   = word[7:5];
    a    = int'(word[4:0]);
    d    = m_stk.size();
    fault = 0; cyc = 0; n_push = 0; n_pop = 0;
    case (op)
      3'd0, 3'd1, 3'd2: begin
        if (d < 2) begin fault = 1; return; end
        x = m_stk.pop_back();
        y = m_stk.pop_back();
        if (op == 3'd0)      m_stk.push_back(x + y);
        else if (op == 3'd1) m_stk.push_back(x - y);
        else                 m_stk.push_back(x & y);
        cyc = 7; n_push = 1; n_pop = 2; m_pc = m_pc + 5'd1;
      end
      3'd3: begin
        if (d < 1) begin fault = 1; return; end
        x = m_stk.pop_back();
        m_stk.push_back(~x);
        cyc = 6; n_push = 1; n_pop = 1; m_pc = m_pc + 5'd1;
      end
      3'd4: begin
        if (d == 32) begin fault = 1; return; end
        m_stk.push_back(m_mem[a]);
        cyc = 4; n_push = 1; m_pc = m_pc + 5'd1;
      end
      3'd5: begin
        if (d < 1) begin fault = 1; return; end
        m_mem[a] = m_stk.pop_back();
        cyc = 4; n_pop = 1; m_pc = m_pc + 5'd1;
      end
      3'd6: begin
        cyc = 3; m_pc = 5'(a);
      end
      default: begin
        if (d < 1) begin fault = 1; return; end
        cyc = 4;
        if (m_stk[$] == 8'd0) m_pc = 5'(a);
        else                  m_pc = m_pc + 5'd1;
      end
    endcase
  endtask

  // Reset both DUT and model from img, then release; ends at FETCH negedge.
  task automatic start_prog();
    rst = 1'b0;
    bus.run = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 32; i++) m_mem[i] = img[i];
    m_pc = '0;
    m_stk.delete();
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Runs up to max_instr instructions, checking each against the model.
  task automatic run_prog(input int max_instr, output bit faulted);
    int         exp_cyc, exp_push, exp_pop, cyc, np, npo;
    bit         fault, done;
    logic [2:0] op;
    faulted = 0;
    for (int k = 0; k < max_instr; k++) begin
      model_step(exp_cyc, exp_push, exp_pop, fault, op);
      n_checks++;
      if (bus.state !== 4'd1) begin
        n_fail++;
        $display("FAIL fetch_state instr %0d: got %0d want 1", k, bus.state);
      end
      if (fault) begin
        @(negedge clk);
        n_checks++;
        if (bus.state !== 4'd2 || bus.PC_Write !== 1'b0 || bus.pop !== 1'b0 || bus.push !== 1'b0) begin
          n_fail++;
          $display("FAIL fault_decode: state=%0d PC_Write=%b pop=%b push=%b want 2/0/0/0",
                   bus.state, bus.PC_Write, bus.pop, bus.push);
        end
        @(negedge clk);
        n_checks++;
        if (bus.state !== 4'd15 || bus.err !== 1'b1 || bus.busy !== 1'b0) begin
          n_fail++;
          $display("FAIL fault_err: state=%0d err=%b busy=%b want 15/1/0", bus.state, bus.err, bus.busy);
        end
        for (int j = 0; j < 4; j++) begin
          bus.run = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        n_checks++;
        if (bus.state !== 4'd15 || bus.err !== 1'b1 || bus.push !== 1'b0 || bus.pop !== 1'b0) begin
          n_fail++;
          $display("FAIL err_sticky: state=%0d err=%b want 15/1", bus.state, bus.err);
        end
        bus.run = 1'b1;
        $display("instr %0d op=%0d fault depth=%0d", k, op, bus.depth);
        faulted = 1;
        return;
      end
      cyc = 1; np = 0; npo = 0; done = 0;
      while (!done && cyc <= 20) begin
        bus.run = 1'($urandom_range(0, 1));
        @(negedge clk);
        cyc++;
        np  += int'(bus.push);
        npo += int'(bus.pop);
        if (bus.state === 4'd7) begin
          n_checks++;
          if (bus.ALU_Control !== op[1:0]) begin
            n_fail++;
            $display("FAIL alu_control instr %0d: got %b want %b", k, bus.ALU_Control, op[1:0]);
          end
        end
        if (bus.instr_done === 1'b1) done = 1;
      end
      n_checks++;
      if (!done) begin
        n_fail++;
        $display("FAIL instr_done_timeout instr %0d: no instr_done within 20 cycles", k);
        return;
      end
      n_checks++;
      if (cyc != exp_cyc || np != exp_push || npo != exp_pop) begin
        n_fail++;
        $display("FAIL cycles_strobes instr %0d op=%0d: cyc=%0d push=%0d pop=%0d want %0d/%0d/%0d",
                 k, op, cyc, np, npo, exp_cyc, exp_push, exp_pop);
      end
      @(negedge clk);
      n_checks++;
      if (int'(bus.depth) != m_stk.size() || sp != m_stk.size() || pc !== m_pc) begin
        n_fail++;
        $display("FAIL arch_state instr %0d: depth=%0d sp=%0d pc=%0d want depth=%0d pc=%0d",
                 k, bus.depth, sp, pc, m_stk.size(), m_pc);
      end
      if (m_stk.size() > 0 && sp > 0) begin
        n_checks++;
        if (stk[sp-1] !== m_stk[$]) begin
          n_fail++;
          $display("FAIL stack_top instr %0d: got %0d want %0d", k, stk[sp-1], m_stk[$]);
        end
      end
      if (op == 3'd5) begin
        n_checks++;
        if (mem[ir[4:0]] !== m_mem[ir[4:0]]) begin
          n_fail++;
          $display("FAIL pop_store instr %0d: got %0d want %0d", k, mem[ir[4:0]], m_mem[ir[4:0]]);
        end
      end
      $display("instr %0d op=%0d cycles=%0d depth=%0d pc=%0d", k, op, cyc, bus.depth, pc);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [17:0] ctl;
    clear_img();
    rst = 1'b0;
    bus.run = 1'b1;
    repeat (2) @(negedge clk);
    ctl = {bus.IorD, bus.MemRead, bus.IR_Write, bus.PC_Write, bus.PCsel, bus.d_in_sel,
           bus.push, bus.pop, bus.MemWrite, bus.ldop1, bus.ldop2, bus.ALU_Src_A,
           bus.ALU_Src_B, bus.tos, bus.JZ, bus.ALU_Control, bus.instr_done};
    n_checks++;
    if (bus.state !== 4'd0 || bus.depth !== 6'd0 || bus.err !== 1'b0 || bus.busy !== 1'b0 || ctl !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d depth=%0d err=%b busy=%b ctl=%h want all 0",
               bus.state, bus.depth, bus.err, bus.busy, ctl);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.state !== 4'd1 || bus.IR_Write !== 1'b1 || bus.MemRead !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: state=%0d IR_Write=%b MemRead=%b busy=%b want 1/1/1/1",
               bus.state, bus.IR_Write, bus.MemRead, bus.busy);
    end
    $display("reset: state=%0d after release", bus.state);
  endtask

  task automatic test_push();
    bit f;
    clear_img();
    img[0] = enc(4, 24); img[1] = enc(4, 25);
    img[24] = 8'd5;      img[25] = 8'd3;
    start_prog();
    run_prog(2, f);
    n_checks++;
    if (bus.depth !== 6'd2 || f !== 1'b0 || stk[1] !== 8'd3 || stk[0] !== 8'd5) begin
      n_fail++;
      $display("FAIL push_pair: depth=%0d stk0=%0d stk1=%0d want 2/5/3", bus.depth, stk[0], stk[1]);
    end
  endtask

  task automatic test_sub();
    bit f;
    clear_img();
    img[0] = enc(4, 24); img[1] = enc(4, 25); img[2] = enc(1, 0);
    img[24] = 8'd3;      img[25] = 8'd5;
    start_prog();
    run_prog(3, f);
    n_checks++;
    if (bus.depth !== 6'd1 || sp != 1 || stk[0] !== 8'd2) begin
      n_fail++;
      $display("FAIL sub_result: depth=%0d top=%0d want 1/2", bus.depth, stk[0]);
    end
  endtask

  task automatic test_jz();
    bit f;
    for (int t = 0; t < 2; t++) begin
      clear_img();
      img[0] = enc(4, 24); img[1] = enc(7, 6);
      img[24] = (t == 0) ? 8'd0 : 8'd7;
      start_prog();
      run_prog(2, f);
      n_checks++;
      if (pc !== ((t == 0) ? 5'd6 : 5'd2) || bus.depth !== 6'd1) begin
        n_fail++;
        $display("FAIL jz_target top=%0d: pc=%0d depth=%0d want %0d/1",
                 img[24], pc, bus.depth, (t == 0) ? 6 : 2);
      end
    end
  endtask

  task automatic test_underflow();
    bit f;
    clear_img();
    img[0] = enc(4, 24); img[1] = enc(0, 0);
    start_prog();
    run_prog(5, f);
    n_checks++;
    if (f !== 1'b1 || bus.depth !== 6'd1) begin
      n_fail++;
      $display("FAIL underflow_trap: faulted=%b depth=%0d want 1/1", f, bus.depth);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.err !== 1'b0 || bus.state !== 4'd0 || bus.depth !== 6'd0) begin
      n_fail++;
      $display("FAIL err_clear: err=%b state=%0d depth=%0d want 0/0/0", bus.err, bus.state, bus.depth);
    end
    rst = 1'b1;
  endtask

  task automatic test_overflow();
    bit f;
    clear_img();
    img[0] = enc(4, 31); img[1] = enc(6, 0);
    img[31] = 8'hA5;
    start_prog();
    run_prog(100, f);
    n_checks++;
    if (f !== 1'b1 || bus.depth !== 6'd32 || sp != 32) begin
      n_fail++;
      $display("FAIL overflow_trap: faulted=%b depth=%0d sp=%0d want 1/32/32", f, bus.depth, sp);
    end
  endtask

  task automatic test_random();
    bit f;
    int d, op;
    for (int r = 0; r < 4; r++) begin
      clear_img();
      for (int i = 24; i < 32; i++) img[i] = 8'($urandom_range(0, 255));
      if (r == 0) img[26] = 8'd0;
      d = 0;
      for (int k = 0; k < 20; k++) begin
        op = $urandom_range(0, 7);
        if ((op <= 2 && d < 2) || ((op == 3 || op == 5 || op == 7) && d < 1)) op = 4;
        if (op == 6 || op == 7) img[k] = enc(op, k + 1);
        else                    img[k] = enc(op, $urandom_range(24, 31));
        if (op <= 2 || op == 5) d = d - 1;
        else if (op == 4)       d = d + 1;
      end
      start_prog();
      run_prog(20, f);
      n_checks++;
      if (f !== 1'b0) begin
        n_fail++;
        $display("FAIL random_no_fault round %0d: faulted=%b want 0", r, f);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.run = 1'b0;
    clear_img();
    test_reset();
    test_push();
    test_sub();
    test_jz();
    test_underflow();
    test_overflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
